// File: rtl/axis_rr_arbiter_if.sv
// rtl/axis_rr_arbiter_if.sv - stream bundle between NUM_REQ requesters and the arbitrated output channel
interface axis_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            s_valid;
  logic [NUM_REQ-1:0]            s_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
  logic [NUM_REQ-1:0]            s_last;
  logic                          m_valid;
  logic                          m_ready;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          m_last;
  logic [ID_W-1:0]               m_grant_id;

  // slave: the arbiter's view; master: the surrounding requesters and sink
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_grant_id
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_grant_id
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - round-robin stream arbiter with registered output; ARB_PKT_LOCK_EN holds grant per packet
module axis_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  axis_rr_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       grant;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_last_q;
  logic [ID_W-1:0]       m_id_q;

  logic                  adv;
  logic                  accept;
  logic                  rel_grant;
  logic                  sel_found;
  logic [ID_W-1:0]       sel_idx;
  logic [ID_W-1:0]       next_ptr;
  logic                  grant_valid;
  logic                  grant_last;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [NUM_REQ-1:0]    s_ready_c;
  int                    idx;

  assign adv = bus.m_ready | ~m_valid_q;

  // Walk backwards so the lowest offset from ptr is the one left standing.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.s_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(idx);
      end
    end
  end

  assign grant_valid = bus.s_valid[grant];
  assign grant_last  = bus.s_last[grant];
  assign grant_data  = bus.s_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign accept      = (state == BUSY) & grant_valid & adv;
  assign next_ptr    = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

`ifdef ARB_PKT_LOCK_EN
  assign rel_grant = accept & grant_last;
`else
  assign rel_grant = accept;
`endif

  always_comb begin
    s_ready_c = '0;
    if (state == BUSY) s_ready_c[grant] = adv;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant <= sel_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (rel_grant) begin
            state <= IDLE;
            ptr   <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase

      // A new beat wins over a drain, so back-to-back beats keep m_valid high.
      if (accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= grant_data;
        m_last_q  <= grant_last;
        m_id_q    <= grant;
      end else if (m_valid_q & bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_last     = m_last_q;
  assign bus.m_grant_id = m_id_q;
endmodule
